truth_table_sweeper: RTL and testbench

- Sequential stimulus-and-capture stage wrapped around a 3-input combinational function block (inputs x, z, y; output f).
- Upstream role: on a start request, it drives all 8 input combinations in ascending binary order.
- Downstream role: it samples f for each combination into an 8-bit truth table and compares the result against an expected table.
- Lets the function blocks be checked in hardware instead of by a hand-written stimulus list.

---
 rtl/truth_table_sweeper.sv | 115 +++++++++++
 tb/tb_truth_table_sweeper.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all eight x/z/y combinations into a 3-input
// function, captures f for each one into an 8-bit table and compares the
// finished table against an expected value.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f,
  output logic       x,
  output logic       z,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic [3:0] mismatch_count
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  // Last settle-counter value before moving to SAMPLE.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [2:0] idx_q;
  logic [3:0] settle_q;
  logic       x_q, z_q, y_q;
  logic       busy_q, done_q, match_q;
  logic [7:0] table_q;
  logic [3:0] mcount_q;

  logic [7:0] table_d;
  logic       miss;

  // Table with the current sample folded in, used for the final match.
  always_comb begin
    table_d        = table_q;
    table_d[idx_q] = f;
    miss           = f ^ EXPECTED[idx_q];
  end

  // Sweep FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      settle_q <= 4'd0;
      x_q      <= 1'b0;
      z_q      <= 1'b0;
      y_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      table_q  <= 8'd0;
      mcount_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          {x_q, z_q, y_q} <= 3'd0;
          if (start) begin
            state_q  <= StDrive;
            idx_q    <= 3'd0;
            settle_q <= 4'd0;
            busy_q   <= 1'b1;
            table_q  <= 8'd0;
            mcount_q <= 4'd0;
            match_q  <= 1'b0;
          end
        end
        StDrive: begin
          if (settle_q == SettleLast) begin
            state_q  <= StSample;
            settle_q <= 4'd0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        StSample: begin
          table_q <= table_d;
          if (miss) mcount_q <= mcount_q + 4'd1;
          if (idx_q == 3'd7) begin
            state_q         <= StDone;
            match_q         <= (table_d == EXPECTED);
            done_q          <= 1'b1;
            {x_q, z_q, y_q} <= 3'd0;
          end else begin
            state_q         <= StDrive;
            idx_q           <= idx_q + 3'd1;
            {x_q, z_q, y_q} <= idx_q + 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          idx_q   <= 3'd0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign x              = x_q;
  assign z              = z_q;
  assign y              = y_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = table_q;
  assign match          = match_q;
  assign mismatch_count = mcount_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: stimulus pushes expected sweep
// results, monitors pop and compare on every done pulse.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start1;
  int         mode;
  logic       f0;
  logic       x0, z0, y0, busy0, done0, match0;
  logic [7:0] tab0;
  logic [3:0] mc0;
  logic       x1, z1, y1, busy1, done1, match1;
  logic [7:0] tab1;
  logic [3:0] mc1;

  // Function under sweep: 0 majority, 1 x&z, 2 constant one.
  always_comb begin
    f0 = 1'b0;
    case (mode)
      0:       f0 = (x0 & z0) | (x0 & y0) | (z0 & y0);
      1:       f0 = x0 & z0;
      default: f0 = 1'b1;
    endcase
  end

  truth_table_sweeper u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .f(f0),
    .x(x0), .z(z0), .y(y0), .busy(busy0), .done(done0),
    .table_out(tab0), .match(match0), .mismatch_count(mc0)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hE8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f(1'b1),
    .x(x1), .z(z1), .y(y1), .busy(busy1), .done(done1),
    .table_out(tab1), .match(match1), .mismatch_count(mc1)
  );

  typedef struct {
    logic [7:0] tab;
    logic       m;
    logic [3:0] mc;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the default instance: vector stepping, done latency, results.
  initial begin
    int   a0;
    int   n;
    logic bprev;
    exp_t e;
    a0    = 0;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bprev = 1'b0;
      end else begin
        if (busy0 && !bprev) a0 = cyc;
        n = cyc - a0 + 1;
        if (busy0 && !done0) chk("vector0", {x0, z0, y0}, 32'((n - 1) / 3));
        if (done0) begin
          chk("done_vector0", {x0, z0, y0}, 0);
          if (q0.size() == 0) begin
            chk("unexpected_done0", 1, 0);
          end else begin
            e = q0.pop_front();
            chk("table0", tab0, e.tab);
            chk("match0", match0, e.m);
            chk("mcount0", mc0, e.mc);
            chk("latency0", n, e.lat);
          end
        end
        bprev = busy0;
      end
    end
  end

  // Monitor for the SETTLE_CYCLES=1 instance.
  initial begin
    int   a1;
    logic bprev;
    exp_t e;
    a1    = 0;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bprev = 1'b0;
      end else begin
        if (busy1 && !bprev) a1 = cyc;
        if (done1) begin
          if (q1.size() == 0) begin
            chk("unexpected_done1", 1, 0);
          end else begin
            e = q1.pop_front();
            chk("table1", tab1, e.tab);
            chk("match1", match1, e.m);
            chk("mcount1", mc1, e.mc);
            chk("latency1", cyc - a1 + 1, e.lat);
          end
        end
        bprev = busy1;
      end
    end
  end

  task automatic push0(input logic [7:0] t, input logic m, input logic [3:0] mc);
    exp_t e;
    e.tab = t; e.m = m; e.mc = mc; e.lat = 25;
    q0.push_back(e);
  endtask

  task automatic pulse0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    for (int k = 0; k < budget && !done0; k++) @(negedge clk);
    chk("done0_seen", done0, 1);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 0;
    #1;
    chk("rst_xzy", {x0, z0, y0}, 0);
    chk("rst_busy_done", {busy0, done0}, 0);
    chk("rst_results", {tab0, match0, mc0}, 0);
    chk("rst_dut1", {x1, z1, y1, busy1, done1, tab1, match1, mc1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Majority function: E8, match, no mismatches.
    mode = 0;
    push0(8'hE8, 1'b1, 4'd0);
    pulse0();
    chk("busy_after_accept", busy0, 1);
    wait_done0(40);
    chk("hold_table", tab0, 8'hE8);
    chk("idle_busy", busy0, 0);

    // x&z: C0, two differing bits.
    mode = 1;
    push0(8'hC0, 1'b0, 4'd2);
    pulse0();
    wait_done0(40);

    // Extra start pulses mid-sweep must be ignored.
    mode = 0;
    push0(8'hE8, 1'b1, 4'd0);
    pulse0();
    repeat (3) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    repeat (6) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    wait_done0(40);
    repeat (3) @(negedge clk);
    chk("no_restart", busy0, 0);

    // Asynchronous reset mid-sweep with f=1 so the table is non-zero.
    mode = 2;
    pulse0();
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_xzy", {x0, z0, y0}, 0);
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_table", tab0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", busy0, 0);

    // Start held high across two sweeps: one idle cycle between them.
    mode = 0;
    push0(8'hE8, 1'b1, 4'd0);
    push0(8'hE8, 1'b1, 4'd0);
    @(negedge clk); start0 = 1'b1;
    for (int k = 0; k < 40 && !done0; k++) @(negedge clk);
    chk("first_done", done0, 1);
    @(negedge clk);
    chk("gap_idle", busy0, 0);
    chk("gap_hold", {tab0, match0, mc0}, {8'hE8, 1'b1, 4'd0});
    @(negedge clk);
    chk("relaunch", busy0, 1);
    repeat (20) @(negedge clk);
    start0 = 1'b0;
    wait_done0(40);
    repeat (3) @(negedge clk);
    chk("two_sweeps_only", busy0, 0);

    // SETTLE_CYCLES=1 with f tied high: FF, four mismatches, done at 17.
    e.tab = 8'hFF; e.m = 1'b0; e.mc = 4'd4; e.lat = 17;
    q1.push_back(e);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k < 30 && !done1; k++) @(negedge clk);
    chk("done1_seen", done1, 1);
    repeat (3) @(negedge clk);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
